reg_bank_param: RTL and testbench

- Parametrised successor to the processor's 32x32 register bank.
- Adds configurable width and depth, write enable, and a hard-wired zero register.
- Adds a synchronous reset-clear sweep, driven by an INIT/READY state machine.
- Adds a per-register busy scoreboard for in-flight writes. Sits between decode (reads, issue) and writeback (writes).

---
 rtl/reg_bank_param.sv | 199 +++++++++++++++++++
 tb/tb_reg_bank_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_param.sv
// ============================================================================
// reg_bank_param
// ----------------------------------------------------------------------------
// Parametrised register bank sitting between decode (reads, issue) and
// writeback (writes). Beyond plain storage it provides:
//   - an optional hard-wired zero register (ZERO_REG),
//   - a reset-clear sweep that zeroes every register after reset, driven by
//     an INIT/READY state machine,
//   - a per-register busy scoreboard tracking in-flight producers.
//
// Parameters:
//   DATA_W    register width in bits
//   ADDR_W    address width; the bank holds 2**ADDR_W registers
//   ZERO_REG  1: register 0 reads 0, drops writes and is never busy
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   rs1_addr    read port 1 address
//   rs2_addr    read port 2 address
//   rs1_data    read port 1 data (combinational)
//   rs2_data    read port 2 data (combinational)
//   rs1_busy    scoreboard bit for rs1_addr
//   rs2_busy    scoreboard bit for rs2_addr
//   rd_we       writeback enable
//   rd_addr     writeback address
//   rd_data     writeback data
//   issue_vld   an instruction targeting issue_addr has been issued
//   issue_addr  destination register of the issued instruction
//   ready       bank initialised and accepting traffic
//
// Configuration macro:
//   REG_BANK_BYPASS_EN  when defined, a writeback to the register being read
//                       in the same cycle is forwarded straight to the read
//                       data. When undefined, reads see the stored value and
//                       the written data appears from the next cycle.
// ============================================================================
module reg_bank_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              rd_we,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              issue_vld,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              ready
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        INIT,
        READY
    } bankState_e;

    bankState_e        state_q;
    logic [ADDR_W-1:0] sweepCnt_q;
    logic              ready_q;
    logic [DATA_W-1:0] regFile_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              isReady;

    assign isReady = (state_q == READY);
    assign ready   = ready_q;

    // An address names the hard-wired zero register only when the feature
    // is enabled; every read/write/scoreboard path funnels through here.
    function automatic logic isZeroAddr(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    // Control FSM. INIT walks the sweep counter across every register and
    // hands over to READY on the edge that clears the last one, so ready
    // rises exactly DEPTH edges after reset is released. ready is kept as
    // its own register so it comes straight off a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT;
            sweepCnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    sweepCnt_q <= sweepCnt_q + ADDR_W'(1);
                    if (sweepCnt_q == LAST_IDX) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    state_q <= READY;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= INIT;
                    sweepCnt_q <= '0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    // Storage. Reset deliberately leaves contents alone; the INIT sweep is
    // what zeroes them, one register per edge. Writeback is only honoured
    // once READY, and writes to the zero register are dropped.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == INIT) begin
                regFile_q[sweepCnt_q] <= '0;
            end else if (rd_we && !isZeroAddr(rd_addr)) begin
                regFile_q[rd_addr] <= rd_data;
            end
        end
    end

    // Scoreboard next state. The writeback clear is applied before the
    // issue set so that a same-address collision leaves the bit set: the
    // freshly issued instruction is a newer producer than the one retiring.
    always_comb begin
        busy_d = busy_q;
        if (isReady) begin
            if (rd_we) begin
                busy_d[rd_addr] = 1'b0;
            end
            if (issue_vld) begin
                busy_d[issue_addr] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    // Scoreboard register, cleared by reset so a rerun sweep starts with no
    // outstanding producers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read port 1. Nothing is visible until the sweep has finished; the zero
    // register always reads 0. With forwarding built in, a same-cycle
    // writeback to the same register overrides the stored value.
    always_comb begin
        rs1_data = '0;
        if (isReady && !isZeroAddr(rs1_addr)) begin
            rs1_data = regFile_q[rs1_addr];
`ifdef REG_BANK_BYPASS_EN
            if (rd_we && (rd_addr == rs1_addr)) begin
                rs1_data = rd_data;
            end
`else
            rs1_data = regFile_q[rs1_addr];
`endif
        end
    end

    // Read port 2, identical to port 1.
    always_comb begin
        rs2_data = '0;
        if (isReady && !isZeroAddr(rs2_addr)) begin
            rs2_data = regFile_q[rs2_addr];
`ifdef REG_BANK_BYPASS_EN
            if (rd_we && (rd_addr == rs2_addr)) begin
                rs2_data = rd_data;
            end
`else
            rs2_data = regFile_q[rs2_addr];
`endif
        end
    end

    // Busy outputs come from the registered scoreboard only, so a clearing
    // write shows up the cycle after it happens, bypass or not.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (isReady) begin
            rs1_busy = busy_q[rs1_addr];
            rs2_busy = busy_q[rs2_addr];
        end
    end

endmodule

// File: tb/tb_reg_bank_param.sv
// ============================================================================
// tb_reg_bank_param
// ----------------------------------------------------------------------------
// Self-checking bench for reg_bank_param at default parameters. A behavioural
// model (array of register values, array of busy flags, count of edges since
// reset release) predicts every output each cycle.
// ============================================================================
module tb_reg_bank_param;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        issue_vld;
    logic [4:0]  issue_addr;
    logic        ready;

    int testCount = 0;
    int failCount = 0;

    logic [31:0] mRegs [32];
    bit          mBusy [32];
    bit          mReady;
    int          mEdges;

    reg_bank_param dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rd_we      (rd_we),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .issue_vld  (issue_vld),
        .issue_addr (issue_addr),
        .ready      (ready)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports one check
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp)
        else begin
            failCount++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Expected read data straight from the rules: nothing before ready,
    // register 0 is always 0, optional same-cycle forwarding.
    function automatic logic [31:0] expData(input logic [4:0] a);
        if (!mReady || a == 5'd0) return 32'h0;
`ifdef REG_BANK_BYPASS_EN
        if (rd_we && rd_addr == a) return rd_data;
`endif
        return mRegs[a];
    endfunction

    function automatic logic [31:0] expBusy(input logic [4:0] a);
        return (mReady && mBusy[a]) ? 32'h1 : 32'h0;
    endfunction

    // Drive the inputs for the coming cycle, then let them settle
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic iv, input logic [4:0] ia,
                                 input logic [4:0] a1, input logic [4:0] a2);
        rd_we      = we;
        rd_addr    = wa;
        rd_data    = wd;
        issue_vld  = iv;
        issue_addr = ia;
        rs1_addr   = a1;
        rs2_addr   = a2;
        #1;
    endtask

    // Compare every output against the model
    task automatic checkOutput(input string tag);
        check32({tag, ".rs1_data"}, rs1_data, expData(rs1_addr));
        check32({tag, ".rs2_data"}, rs2_data, expData(rs2_addr));
        check32({tag, ".rs1_busy"}, {31'h0, rs1_busy}, expBusy(rs1_addr));
        check32({tag, ".rs2_busy"}, {31'h0, rs2_busy}, expBusy(rs2_addr));
        check32({tag, ".ready"}, {31'h0, ready}, {31'h0, mReady});
    endtask

    // Advance one clock edge and update the model with the inputs seen there
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            mReady = 1'b0;
            mEdges = 0;
            foreach (mBusy[i]) mBusy[i] = 1'b0;
        end else if (!mReady) begin
            mEdges++;
            if (mEdges == 32) begin
                mReady = 1'b1;
                foreach (mRegs[i]) mRegs[i] = 32'h0;
            end
        end else begin
            if (rd_we && rd_addr != 5'd0) mRegs[rd_addr] = rd_data;
            if (rd_we) mBusy[rd_addr] = 1'b0;
            if (issue_vld && issue_addr != 5'd0) mBusy[issue_addr] = 1'b1;
        end
        #1;
    endtask

    // Run the sweep with traffic that must be ignored; count edges to ready
    task automatic waitReady(input string tag);
        int n = 0;
        do begin
            applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'($urandom), 5'($urandom));
            checkOutput(tag);
            tick();
            n++;
        end while (ready !== 1'b1 && n < 100);
        check32({tag, ".edges_to_ready"}, n, 32);
    endtask

    initial begin
        logic [4:0] a;
        rst_n = 1'b0;
        foreach (mRegs[i]) mRegs[i] = 32'h0;
        foreach (mBusy[i]) mBusy[i] = 1'b0;
        mReady = 1'b0;
        mEdges = 0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

        // Reset held low three cycles; state is defined after the first edge
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
            checkOutput("reset");
            tick();
        end

        // Sweep, with a write to reg 5 during INIT that must be lost
        rst_n = 1'b1;
        waitReady("sweep");
        for (int i = 0; i < 32; i += 2) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(i + 1));
            checkOutput("sweep_read");
            tick();
        end

        // Basic write/read
        applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd1, 5'd2);
        checkOutput("wr7");
        tick();
        applyStimulus(1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd7, 5'd2);
        checkOutput("wr31");
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd31);
        checkOutput("rd7_31");
        check32("rd7_const", rs1_data, 32'h12345678);
        check32("rd31_const", rs2_data, 32'hFFFFFFFF);
        tick();

        // Zero register: write and issue both ignored
        applyStimulus(1'b1, 5'd0, 32'hA5A5A5A5, 1'b1, 5'd0, 5'd0, 5'd7);
        checkOutput("zero_wr");
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        checkOutput("zero_rd");
        check32("zero_data_const", rs1_data, 32'h0);
        check32("zero_busy_const", {31'h0, rs1_busy}, 32'h0);
        tick();

        // Scoreboard: issue, clear by write, then same-cycle issue+write
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
        checkOutput("sb_issue");
        tick();
        applyStimulus(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd1);
        checkOutput("sb_busy");
        check32("sb_busy_const", {31'h0, rs1_busy}, 32'h1);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd1);
        checkOutput("sb_cleared");
        check32("sb_clear_const", {31'h0, rs1_busy}, 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
        checkOutput("sb_setwins");
        check32("sb_setwins_busy", {31'h0, rs1_busy}, 32'h1);
        check32("sb_setwins_data", rs1_data, 32'h55);
        tick();

        // Same-cycle write/read of reg 3
        applyStimulus(1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 5'd0, 5'd3, 5'd4);
        checkOutput("bypass_same");
`ifdef REG_BANK_BYPASS_EN
        check32("bypass_same_const", rs1_data, 32'hCAFEF00D);
`else
        check32("bypass_same_const", rs1_data, 32'h0);
`endif
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
        checkOutput("bypass_next");
        check32("bypass_next_const", rs1_data, 32'hCAFEF00D);
        tick();

        // Mid-operation reset with reg 4 written and busy
        applyStimulus(1'b1, 5'd4, 32'h77, 1'b0, 5'd0, 5'd4, 5'd0);
        checkOutput("mid_wr4");
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0);
        checkOutput("mid_issue4");
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0);
        checkOutput("mid_busy4");
        check32("mid_busy4_const", {31'h0, rs1_busy}, 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
        checkOutput("mid_reset");
        check32("mid_reset_ready", {31'h0, ready}, 32'h0);
        waitReady("mid_sweep");
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd7);
        checkOutput("mid_after");
        check32("mid_reg4_const", rs1_data, 32'h0);
        check32("mid_busy4_clr", {31'h0, rs1_busy}, 32'h0);
        tick();

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            a = 5'($urandom_range(0, 31));
            applyStimulus(1'($urandom), 5'($urandom_range(0, 31)), $urandom,
                          1'($urandom), 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) begin
                rd_addr = rs1_addr;
                #1;
            end
            checkOutput("rand");
            tick();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
